// File: rtl/fifo_drain_pkg.sv
// Shared read-side definitions for the 8-entry sync FIFO and its drain master.
// Holds state encodings, FIFO geometry and the read-issue credit rule.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_ERR   = 2'b11
  } rd_state_e;

  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_RD_LAT = 1;
  localparam int SKID_DEPTH  = 2;

  // A new read may go out only if the word it returns is guaranteed a skid slot:
  // buffered + in-flight - leaving this cycle must stay below SKID_DEPTH.
  function automatic logic issue_ok(input logic [1:0] occ, input logic inflight, input logic pop);
    return ({1'b0, occ} + {2'b00, inflight}) < (3'(SKID_DEPTH) + {2'b00, pop});
  endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// 2-entry in-order skid buffer; head is registered, valid whenever occupied.
// Latency: push visible at head one cycle later; caller must never push while full.
module fifo_drain_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] ent0;
  logic [DATA_WIDTH-1:0] ent1;
  logic [1:0]            occ_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent0  <= '0;
      ent1  <= '0;
      occ_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            ent0  <= push_data;
            occ_q <= 2'd1;
          end else if (occ_q == 2'd1) begin
            ent1  <= push_data;
            occ_q <= 2'd2;
          end
        end
        2'b01: begin
          ent0  <= ent1;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands directly behind the departing head.
          if (occ_q == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ       = occ_q;
  assign valid     = (occ_q != 2'd0);
  assign head_data = ent0;

endmodule

// File: rtl/fifo_drain.sv
// Read master for the sync FIFO: issues reads, absorbs the 1-cycle read latency, streams words out.
// Sustains 1 word/cycle; under m_ready backpressure reads stop once the 2-entry skid is committed.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clr_err,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_rd_ack,
  input  logic                  fifo_rd_err,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic                  err_flag
);

  rd_state_e  state;
  rd_state_e  state_nxt;
  logic       inflight;
  logic       pop;
  logic       push;
  logic       rsp_err;
  logic [1:0] occ;

  assign pop     = m_valid & m_ready;
  assign push    = inflight & fifo_rd_ack & ~fifo_rd_err;
  // A response slot with no ack is as bad as an explicit reject.
  assign rsp_err = inflight & ~push;

  fifo_drain_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(fifo_dout),
    .pop      (pop),
    .occ      (occ),
    .valid    (m_valid),
    .head_data(m_data)
  );

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN: begin
        fifo_rd_en = enable & ~fifo_empty & issue_ok(occ, inflight, pop);
        if (rsp_err)
          state_nxt = ST_ERR;
        else if ((occ == 2'd2) && !pop)
          state_nxt = ST_STALL;
      end
      ST_STALL: begin
        if (rsp_err)
          state_nxt = ST_ERR;
        else if (pop || (occ < 2'd2))
          state_nxt = ST_RUN;
      end
      ST_ERR: begin
        if (clr_err && !rsp_err)
          state_nxt = ST_RUN;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_INIT;
      inflight   <= 1'b0;
      err_flag   <= 1'b0;
      xfer_count <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      // A fresh error outranks a clear arriving in the same cycle.
      if (rsp_err)
        err_flag <= 1'b1;
      else if (clr_err)
        err_flag <= 1'b0;
      if (pop)
        xfer_count <= xfer_count + CNT_WIDTH'(1);
    end
  end

endmodule
